// File: rtl/fp_add_control.sv
// fp_add_control
//   Multi-cycle sequencer for the floating-point adder datapath. On start it
//   latches which operand has the larger exponent (swap mux select) and the
//   alignment distance. It then steps the 28-bit alignment shifter one bit
//   per cycle and issues the add, normalize and round strobes. Completion is
//   signalled with a one-cycle done pulse. No mantissa data is held here.
//
//   Optional build macro: FP_ADD_CTRL_BYPASS_EN
//     Adds output 'bypass'. When the exponent gap exceeds MAX_SHIFT, LOAD goes
//     straight to ROUND. In that case the result is simply the larger operand.
//
//   Ports
//     clk, reset        clock; synchronous active-high reset
//     start             new add request, accepted only in IDLE
//     exp_a, exp_b      operand exponents, captured with start
//     sum_carry         sum overflowed into bit MANT_W-1
//     sum_msb           hidden-bit position of the sum is set
//     mant_zero         mantissa sum is all zero
//     sel_swap          1 = B is the larger operand (held until next start)
//     load_ops          load operand registers through the swap muxes
//     shift_right_en    shift the smaller mantissa right by one
//     add_en            perform the mantissa add
//     norm_right/left   normalize the sum by one bit (combinational in NORM)
//     exp_inc/exp_dec   result exponent adjust, paired with norm_right/left
//     round_en          perform rounding
//     busy              high in every state except IDLE
//     done              one-cycle completion pulse
//     bypass            (macro only) result is the larger operand
//     zero_result       result is zero, held until the next accepted start
module fp_add_control #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 28,
  parameter int MAX_SHIFT = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             sum_carry,
  input  logic             sum_msb,
  input  logic             mant_zero,
  output logic             sel_swap,
  output logic             load_ops,
  output logic             shift_right_en,
  output logic             add_en,
  output logic             norm_right,
  output logic             norm_left,
  output logic             exp_inc,
  output logic             exp_dec,
  output logic             round_en,
  output logic             busy,
  output logic             done,
`ifdef FP_ADD_CTRL_BYPASS_EN
  output logic             bypass,
`endif
  output logic             zero_result
);

  localparam int CNT_W  = $clog2(MAX_SHIFT + 1);
  localparam int NCNT_W = $clog2(MANT_W);
  localparam logic [EXP_W-1:0]  SHIFT_LIM = EXP_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0]  SHIFT_SAT = CNT_W'(MAX_SHIFT);
  // Left-shift count value on which the last permitted left shift happens
  // (MANT_W-1 shifts in total).
  localparam logic [NCNT_W-1:0] NORM_PEN  = NCNT_W'(MANT_W - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  shift_cnt;
  logic [NCNT_W-1:0] norm_cnt;
  logic [EXP_W-1:0]  diff;
  logic [CNT_W-1:0]  shift_sat;
  logic              in_norm;

  // Unsigned exponent gap and its saturated shift count.
  always_comb begin
    diff      = (exp_a > exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);
    shift_sat = (diff > SHIFT_LIM) ? SHIFT_SAT : diff[CNT_W-1:0];
  end

  // NORM strobes are Mealy on the datapath flags; mant_zero wins, then carry.
  assign in_norm    = (state == S_NORM);
  assign norm_right = in_norm & ~mant_zero & sum_carry;
  assign norm_left  = in_norm & ~mant_zero & ~sum_carry & ~sum_msb;
  assign exp_inc    = norm_right;
  assign exp_dec    = norm_left;

`ifdef FP_ADD_CTRL_BYPASS_EN
  logic big_gap;
`endif

  // Registered strobes are set on the transition into the state that owns
  // them. They are therefore a pure function of the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      shift_cnt      <= '0;
      norm_cnt       <= '0;
      sel_swap       <= 1'b0;
      load_ops       <= 1'b0;
      shift_right_en <= 1'b0;
      add_en         <= 1'b0;
      round_en       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      zero_result    <= 1'b0;
`ifdef FP_ADD_CTRL_BYPASS_EN
      bypass         <= 1'b0;
      big_gap        <= 1'b0;
`endif
    end else begin
      load_ops       <= 1'b0;
      shift_right_en <= 1'b0;
      add_en         <= 1'b0;
      round_en       <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_LOAD;
            load_ops    <= 1'b1;
            busy        <= 1'b1;
            sel_swap    <= (exp_b > exp_a);
            shift_cnt   <= shift_sat;
            norm_cnt    <= '0;
            zero_result <= 1'b0;
`ifdef FP_ADD_CTRL_BYPASS_EN
            bypass      <= 1'b0;
            big_gap     <= (diff > SHIFT_LIM);
`endif
          end
        end
        S_LOAD: begin
`ifdef FP_ADD_CTRL_BYPASS_EN
          if (big_gap) begin
            // Smaller operand is shifted out entirely: skip to rounding.
            state    <= S_ROUND;
            round_en <= 1'b1;
            bypass   <= 1'b1;
          end else
`endif
          if (shift_cnt != '0) begin
            state          <= S_ALIGN;
            shift_right_en <= 1'b1;
          end else begin
            state  <= S_ADD;
            add_en <= 1'b1;
          end
        end
        S_ALIGN: begin
          shift_cnt <= shift_cnt - 1'b1;
          if (shift_cnt == CNT_W'(1)) begin
            state  <= S_ADD;
            add_en <= 1'b1;
          end else begin
            shift_right_en <= 1'b1;
          end
        end
        S_ADD: begin
          state <= S_NORM;
        end
        S_NORM: begin
          if (mant_zero) begin
            zero_result <= 1'b1;
            state       <= S_DONE;
            done        <= 1'b1;
          end else if (sum_carry) begin
            state    <= S_ROUND;
            round_en <= 1'b1;
          end else if (!sum_msb) begin
            norm_cnt <= norm_cnt + 1'b1;
            if (norm_cnt == NORM_PEN) begin
              state    <= S_ROUND;
              round_en <= 1'b1;
            end
          end else begin
            state    <= S_ROUND;
            round_en <= 1'b1;
          end
        end
        S_ROUND: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_control.sv
// Self-checking bench for fp_add_control. A per-operation reference model
// expands each request into the expected cycle-by-cycle output trace. The
// datapath flags are driven according to the planned NORM behaviour and are
// random elsewhere.
module tb_fp_add_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] exp_a = '0, exp_b = '0;
  logic       sum_carry = 1'b0, sum_msb = 1'b0, mant_zero = 1'b0;
  logic sel_swap, load_ops, shift_right_en, add_en, norm_right, norm_left;
  logic exp_inc, exp_dec, round_en, busy, done, zero_result, bypass_w;

  int checks = 0;
  int failures = 0;

  fp_add_control dut (
    .clk(clk), .reset(reset), .start(start), .exp_a(exp_a), .exp_b(exp_b),
    .sum_carry(sum_carry), .sum_msb(sum_msb), .mant_zero(mant_zero),
    .sel_swap(sel_swap), .load_ops(load_ops), .shift_right_en(shift_right_en),
    .add_en(add_en), .norm_right(norm_right), .norm_left(norm_left),
    .exp_inc(exp_inc), .exp_dec(exp_dec), .round_en(round_en), .busy(busy),
    .done(done),
`ifdef FP_ADD_CTRL_BYPASS_EN
    .bypass(bypass_w),
`endif
    .zero_result(zero_result)
  );
`ifndef FP_ADD_CTRL_BYPASS_EN
  assign bypass_w = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic busy, sel, load, shift, add, nr, nl, ei, ed, rnd, done, zr, byp;
  } obs_t;

  obs_t exp_q[$];
  int   nidx_q[$];   // NORM cycle index, -1 other busy cycle, -2 idle
  obs_t got_q[$];

  function automatic obs_t sample();
    obs_t o;
    o = {busy, sel_swap, load_ops, shift_right_en, add_en, norm_right,
         norm_left, exp_inc, exp_dec, round_en, done, zero_result, bypass_w};
    return o;
  endfunction

  // mode 0: msb clear for the first nleft NORM cycles then set
  // mode 1: carry out of the add; mode 2: zero sum
  task automatic build(input int a, input int b, input int mode, input int nleft);
    obs_t o;
    bit   sw, zr, byp;
    int   d, n, j, left;
    exp_q.delete(); nidx_q.delete();
    sw = (b > a);
    d  = (a > b) ? a - b : b - a;
    zr = 0; byp = 0;
    o = '0; o.busy = 1; o.sel = sw; o.load = 1;
    exp_q.push_back(o); nidx_q.push_back(-1);
`ifdef FP_ADD_CTRL_BYPASS_EN
    if (d > 28) begin
      byp = 1;
      o = '0; o.busy = 1; o.sel = sw; o.rnd = 1; o.byp = 1;
      exp_q.push_back(o); nidx_q.push_back(-1);
      o = '0; o.busy = 1; o.sel = sw; o.done = 1; o.byp = 1;
      exp_q.push_back(o); nidx_q.push_back(-1);
      o = '0; o.sel = sw; o.byp = 1;
      exp_q.push_back(o); nidx_q.push_back(-2);
      return;
    end
`endif
    n = (d > 28) ? 28 : d;
    for (int i = 0; i < n; i++) begin
      o = '0; o.busy = 1; o.sel = sw; o.shift = 1;
      exp_q.push_back(o); nidx_q.push_back(-1);
    end
    o = '0; o.busy = 1; o.sel = sw; o.add = 1;
    exp_q.push_back(o); nidx_q.push_back(-1);
    j = 0; left = 0;
    forever begin
      o = '0; o.busy = 1; o.sel = sw;
      if (mode == 2) begin
        exp_q.push_back(o); nidx_q.push_back(j); zr = 1; break;
      end else if (mode == 1) begin
        o.nr = 1; o.ei = 1; exp_q.push_back(o); nidx_q.push_back(j); break;
      end else if (j < nleft) begin
        o.nl = 1; o.ed = 1; exp_q.push_back(o); nidx_q.push_back(j);
        left++; j++;
        if (left == 27) break;
      end else begin
        exp_q.push_back(o); nidx_q.push_back(j); break;
      end
    end
    if (!zr) begin
      o = '0; o.busy = 1; o.sel = sw; o.rnd = 1;
      exp_q.push_back(o); nidx_q.push_back(-1);
    end
    o = '0; o.busy = 1; o.sel = sw; o.done = 1; o.zr = zr;
    exp_q.push_back(o); nidx_q.push_back(-1);
    o = '0; o.sel = sw; o.zr = zr; o.byp = byp;
    exp_q.push_back(o); nidx_q.push_back(-2);
  endtask

  // Entered and left at posedge+2 of an IDLE cycle. noise: 0 start low while
  // busy, 1 random start while busy, 2 start held high while busy.
  task automatic run_op(input int a, input int b, input int mode,
                        input int nleft, input int noise);
    int j;
    build(a, b, mode, nleft);
    got_q.delete();
    exp_a = 8'(a); exp_b = 8'(b); start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      j = nidx_q[i];
      if (j == -2) start = 1'b0;
      else start = (noise == 2) ? 1'b1 : (noise == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      exp_a = 8'($urandom); exp_b = 8'($urandom);
      sum_carry = 1'($urandom_range(0, 1));
      sum_msb   = 1'($urandom_range(0, 1));
      mant_zero = 1'($urandom_range(0, 1));
      if (j >= 0) begin
        if (mode == 2) mant_zero = 1'b1;
        else if (mode == 1) begin mant_zero = 1'b0; sum_carry = 1'b1; end
        else begin
          mant_zero = 1'b0; sum_carry = 1'b0; sum_msb = (j >= nleft);
        end
      end
      #1;
      got_q.push_back(sample());
      if (j != -2) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset();
    obs_t z;
    z = '0;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sample() !== z) begin
        failures++;
        $display("FAIL reset_idle cycle %0d got=%h exp=%h", i, sample(), z);
      end
      @(posedge clk); #2;
    end
    exp_a = 8'd100; exp_b = 8'd130; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({busy, sel_swap, shift_right_en} !== 3'b111) begin
      failures++;
      $display("FAIL pre_reset_align got=%b exp=111", {busy, sel_swap, shift_right_en});
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; #1;
    for (int i = 0; i < 35; i++) begin
      sum_carry = 1'($urandom_range(0, 1));
      sum_msb   = 1'($urandom_range(0, 1));
      mant_zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (sample() !== z) begin
        failures++;
        $display("FAIL reset_mid_align cycle %0d got=%h exp=%h", i, sample(), z);
      end
      @(posedge clk); #1;
    end
    #1;
  endtask

  task automatic test_align_basic();
    run_op(130, 127, 0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL align_basic cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_carry();
    run_op(100, 100, 1, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL carry cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_norm_left();
    run_op(10, 12, 0, 3, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL norm_left cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
    run_op(50, 50, 0, 40, 0);   // left-shift limit
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL norm_left_limit cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_busy_start();
    run_op(20, 25, 2, 0, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL zero_busy_start cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_large_gap();
    run_op(200, 0, 0, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL large_gap cycle %0d got=%h exp=%h", i + 1, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, b, mode, nleft;
    for (int t = 0; t < 40; t++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) b = $urandom_range(0, 255);
      else begin
        b = a + $urandom_range(0, 10) - 5;
        if (b < 0) b = 0;
        if (b > 255) b = 255;
      end
      mode  = $urandom_range(0, 2);
      nleft = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 30) : $urandom_range(0, 4);
      run_op(a, b, mode, nleft, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL back_to_back op %0d a=%0d b=%0d cycle %0d got=%h exp=%h",
                   t, a, b, i + 1, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_align_basic();
    test_carry();
    test_norm_left();
    test_zero_busy_start();
    test_large_gap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
